oc8051_alu_iter: RTL
====================

Name: oc8051_alu_iter

Overview:
Parametrised, sequential successor to the 8051 core ALU, with operand width set by WIDTH.
- Add, subtract and logic ops are registered and take one cycle.
- Multiply and divide are iterative, one bit per cycle, and share a single shift-register datapath.
- A start/busy/done handshake links it to the decoder/execute stage, so wide MUL/DIV no longer sit on the combinational critical path.

Parameters:
WIDTH, 8, operand/result width; even, 8..32.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  operation request; accepted only when busy=0
op_code  in  4  operation select (package constants)
src1  in  WIDTH  first operand / dividend / multiplicand
src2  in  WIDTH  second operand / divisor / multiplier
srcCy  in  1  carry/borrow in
srcAc  in  1  aux carry in (passed through on NOP)
busy  out  1  iterative op in progress
done  out  1  one-cycle pulse; results valid from this cycle
des_acc  out  WIDTH  primary result (sum, low product, quotient)
des2  out  WIDTH  secondary result (high product, remainder)
desCy  out  1  carry/borrow out
desAc  out  1  aux carry out
desOv  out  1  overflow out

Behaviour:
- Reset: busy=0, done=0, all result/flag outputs 0; FSM to IDLE; an in-flight op is aborted with no done.
- FSM states:
  - IDLE: on start, latch op_code/src1/src2/srcCy/srcAc.
    - Single-cycle op or DIV by zero: go to IDLE, done at T+1.
    - MUL/DIV: go to EXEC, load the iteration counter ($clog2(WIDTH)+1 bits).
  - EXEC: busy=1; one bit per cycle; after the last iteration, go to IDLE with outputs written and done=1.
- Latency, with start accepted at T:
  - Single-cycle ops: done at T+1.
  - MUL/DIV: busy during T+1..T+WIDTH, done at T+WIDTH+1.
- Handshake:
  - start while busy=1 is ignored.
  - busy=0 in the done cycle, so start in that cycle is accepted (back-to-back).
  - Operand changes while busy have no effect.
- Outputs hold their last values until the next done.
- ADD: des_acc = src1+src2+srcCy mod 2^WIDTH.
  - desCy = carry out of MSB; desAc = carry out of bit 3.
  - desOv = signed overflow; des2 = 0.
- SUB: des_acc = src1-src2-srcCy.
  - desCy = borrow from MSB; desAc = borrow from bit 3.
  - desOv = signed overflow; des2 = 0.
- MUL: unsigned, shift-add.
  - des_acc = product[WIDTH-1:0]; des2 = product[2*WIDTH-1:WIDTH].
  - desOv = |des2; desCy = 0; desAc = 0.
- DIV: unsigned, restoring.
  - des_acc = quotient; des2 = remainder; desOv = 0; desCy = 0; desAc = 0.
- DIV with src2=0: no EXEC, done at T+1.
  - des_acc = all ones; des2 = src1; desOv = 1; desCy = 0.
- AND/OR/XOR: bitwise into des_acc; NOT: des_acc = ~src1.
  - For all four: des2 = 0; desCy = srcCy; desAc = 0; desOv = 0.
- NOP and any undefined op_code: des_acc = src1; des2 = src2; desCy = srcCy; desAc = srcAc; desOv = 0; latency 1.

Optional Feature:
OC8051_ALU_EARLY_TERM_EN
- Defined: MUL runs EXEC for (index of highest set bit of src2)+1 cycles and finishes when the remaining multiplier bits are zero.
  - src2=0: no EXEC, done at T+1, product 0.
  - Results are identical to the fixed-latency case.
- Undefined: MUL always takes WIDTH EXEC cycles.
- DIV is unaffected either way.

Decomposition:
- Package oc8051_alu_iter_pkg:
  - op-code localparams ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_NOP;
  - state enum typedef (IDLE, EXEC).
- Sub-module oc8051_alu_iter_muldiv holds the shared 2*WIDTH accumulator/shift register, the iteration counter and the early-termination detect.
- The top level holds the FSM, single-cycle ops and output registers.

Test Plan:
1. WIDTH=8, ADD 0x7F+0x01, Cy=0 -> des_acc 0x80, Cy0, Ac1, Ov1, done at T+1, busy never 1.
2. SUB 0x00-0x01, Cy=0 -> des_acc 0xFF, Cy1, Ac1, Ov0; then XOR 0xA5^0xFF with Cy=1 -> 0x5A, desCy 1.
3. MUL 0xFF*0xFF -> des_acc 0x01, des2 0xFE, Ov1; busy T+1..T+8, done T+9; a start at T+4 is ignored.
4. DIV 0xFB/0x12 -> des_acc 0x0D, des2 0x11, Ov0, done T+9; DIV 0x37/0x00 -> done T+1, des_acc 0xFF, des2 0x37, Ov1.
5. rst asserted at T+5 of a MUL -> busy 0, all outputs 0 next cycle, no done; new ADD accepted right after.
6. WIDTH=16, MUL 0xFFFF*0x0002 -> des_acc 0xFFFE, des2 0x0001, Ov1.
   - Without EARLY_TERM: done T+17.
   - With EARLY_TERM: done T+3.

Source files
------------

// File: rtl/oc8051_alu_iter_pkg.sv
// Shared op codes, FSM state type and helpers for the iterative 8051-style ALU.
package oc8051_alu_iter_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_DIV = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;
  localparam logic [3:0] ALU_NOT = 4'h7;
  localparam logic [3:0] ALU_NOP = 4'h8;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Number of significant bits in v (0 for v == 0).
  function automatic logic [5:0] bit_len(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/oc8051_alu_iter_if.sv
// Request/result bundle between the execute stage and the iterative ALU.
interface oc8051_alu_iter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             srcCy;
  logic             srcAc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] des_acc;
  logic [WIDTH-1:0] des2;
  logic             desCy;
  logic             desAc;
  logic             desOv;

  modport master (
    output start, op_code, src1, src2, srcCy, srcAc,
    input  busy, done, des_acc, des2, desCy, desAc, desOv
  );

  modport slave (
    input  start, op_code, src1, src2, srcCy, srcAc,
    output busy, done, des_acc, des2, desCy, desAc, desOv
  );
endinterface

// File: rtl/oc8051_alu_iter_muldiv.sv
// Shared shift-register datapath: shift-add multiply and restoring divide, one bit per step.
// With OC8051_ALU_EARLY_TERM_EN, MUL only iterates over the significant multiplier bits.
module oc8051_alu_iter_muldiv
  import oc8051_alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             div_sel,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] res_lo_c,
  output logic [WIDTH-1:0] res_hi_c
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    step_c;
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_new;

  // MUL: {hi,lo} = partial product : remaining multiplier, shifted right each step.
  // DIV: {hi,lo} = remainder : dividend/quotient, shifted left each step.
  always_comb begin
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    rem_sh  = acc_q[W2-1:WIDTH-1];
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_new = rem_ge ? WIDTH'(rem_sh - {1'b0, opnd_q}) : rem_sh[WIDTH-1:0];
    if (div_q) step_c = {rem_new, acc_q[WIDTH-2:0], rem_ge};
    else       step_c = {mul_sum, acc_q[WIDTH-1:1]};
  end

  assign last_c = (cnt_q == CW'(1));

`ifdef OC8051_ALU_EARLY_TERM_EN
  logic [CW-1:0] sh_q;
  // A shortened MUL leaves the product left-aligned by the skipped iterations.
  assign {res_hi_c, res_lo_c} = step_c >> sh_q;
`else
  assign {res_hi_c, res_lo_c} = step_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
`ifdef OC8051_ALU_EARLY_TERM_EN
      sh_q   <= '0;
`endif
    end else if (load) begin
      acc_q  <= {WIDTH'(0), (div_sel ? a : b)};
      opnd_q <= div_sel ? b : a;
      div_q  <= div_sel;
`ifdef OC8051_ALU_EARLY_TERM_EN
      cnt_q  <= div_sel ? CW'(WIDTH) : CW'(bit_len(32'(b)));
      sh_q   <= div_sel ? CW'(0) : CW'(WIDTH) - CW'(bit_len(32'(b)));
`else
      cnt_q  <= CW'(WIDTH);
`endif
    end else if (step) begin
      acc_q  <= step_c;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/oc8051_alu_iter.sv
// Sequential 8051-style ALU: one-cycle add/sub/logic, iterative MUL/DIV behind start/busy/done.
// Optional build macro: OC8051_ALU_EARLY_TERM_EN (MUL stops after the top set multiplier bit).
module oc8051_alu_iter
  import oc8051_alu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  oc8051_alu_iter_if.slave  bus
);

  state_e           state_q, state_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [WIDTH-1:0] acc_q, acc_nxt;
  logic [WIDTH-1:0] hi_q, hi_nxt;
  logic             cy_q, cy_nxt;
  logic             ac_q, ac_nxt;
  logic             ov_q, ov_nxt;
  logic             div_op_q, div_op_nxt;

  logic             md_load, md_step, md_div_sel, md_last_c;
  logic [WIDTH-1:0] md_lo_c, md_hi_c;

  logic [WIDTH:0]   add_c, sub_c;
  logic [WIDTH-1:0] sc_acc, sc_hi;
  logic             sc_cy, sc_ac, sc_ov;

  oc8051_alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .div_sel  (md_div_sel),
    .step     (md_step),
    .a        (bus.src1),
    .b        (bus.src2),
    .last_c   (md_last_c),
    .res_lo_c (md_lo_c),
    .res_hi_c (md_hi_c)
  );

  // Single-cycle results; nibble carry/borrow recovered from the bit-4 sum.
  always_comb begin
    add_c  = {1'b0, bus.src1} + {1'b0, bus.src2} + {WIDTH'(0), bus.srcCy};
    sub_c  = {1'b0, bus.src1} - {1'b0, bus.src2} - {WIDTH'(0), bus.srcCy};
    sc_acc = bus.src1;
    sc_hi  = '0;
    sc_cy  = bus.srcCy;
    sc_ac  = 1'b0;
    sc_ov  = 1'b0;
    case (bus.op_code)
      ALU_ADD: begin
        sc_acc = add_c[WIDTH-1:0];
        sc_cy  = add_c[WIDTH];
        sc_ac  = bus.src1[4] ^ bus.src2[4] ^ add_c[4];
        sc_ov  = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (add_c[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_acc = sub_c[WIDTH-1:0];
        sc_cy  = sub_c[WIDTH];
        sc_ac  = bus.src1[4] ^ bus.src2[4] ^ sub_c[4];
        sc_ov  = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (sub_c[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      ALU_AND: sc_acc = bus.src1 & bus.src2;
      ALU_OR:  sc_acc = bus.src1 | bus.src2;
      ALU_XOR: sc_acc = bus.src1 ^ bus.src2;
      ALU_NOT: sc_acc = ~bus.src1;
      default: begin
        sc_hi = bus.src2;
        sc_ac = bus.srcAc;
      end
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    acc_nxt    = acc_q;
    hi_nxt     = hi_q;
    cy_nxt     = cy_q;
    ac_nxt     = ac_q;
    ov_nxt     = ov_q;
    div_op_nxt = div_op_q;
    md_load    = 1'b0;
    md_step    = 1'b0;
    md_div_sel = (bus.op_code == ALU_DIV);
    case (state_q)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.start) begin
          if (bus.op_code == ALU_DIV && bus.src2 == '0) begin
            done_nxt = 1'b1;
            acc_nxt  = '1;
            hi_nxt   = bus.src1;
            cy_nxt   = 1'b0;
            ac_nxt   = 1'b0;
            ov_nxt   = 1'b1;
          end
`ifdef OC8051_ALU_EARLY_TERM_EN
          else if (bus.op_code == ALU_MUL && bus.src2 == '0) begin
            done_nxt = 1'b1;
            acc_nxt  = '0;
            hi_nxt   = '0;
            cy_nxt   = 1'b0;
            ac_nxt   = 1'b0;
            ov_nxt   = 1'b0;
          end
`endif
          else if (bus.op_code == ALU_MUL || bus.op_code == ALU_DIV) begin
            md_load    = 1'b1;
            div_op_nxt = (bus.op_code == ALU_DIV);
            state_nxt  = EXEC;
            busy_nxt   = 1'b1;
          end else begin
            done_nxt = 1'b1;
            acc_nxt  = sc_acc;
            hi_nxt   = sc_hi;
            cy_nxt   = sc_cy;
            ac_nxt   = sc_ac;
            ov_nxt   = sc_ov;
          end
        end
      end
      EXEC: begin
        md_step = 1'b1;
        if (md_last_c) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          acc_nxt   = md_lo_c;
          hi_nxt    = md_hi_c;
          cy_nxt    = 1'b0;
          ac_nxt    = 1'b0;
          ov_nxt    = div_op_q ? 1'b0 : (|md_hi_c);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      cy_q     <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
      div_op_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      acc_q    <= acc_nxt;
      hi_q     <= hi_nxt;
      cy_q     <= cy_nxt;
      ac_q     <= ac_nxt;
      ov_q     <= ov_nxt;
      div_op_q <= div_op_nxt;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.des_acc = acc_q;
  assign bus.des2    = hi_q;
  assign bus.desCy   = cy_q;
  assign bus.desAc   = ac_q;
  assign bus.desOv   = ov_q;

endmodule
